// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute/writeback control FSM driving PC select/load and datapath strobes.
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic             halt_instr,
    input  logic             stall,
    input  logic             branch_taken,
    output logic [1:0]       sel_pc,
    output logic             load_pc,
    output logic             imem_req,
    output logic             load_ir,
    output logic             exec_en,
    output logic             wb_en,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD_START,
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_pc   = 2'b00;
        load_pc  = 1'b0;
        imem_req = 1'b0;
        load_ir  = 1'b0;
        exec_en  = 1'b0;
        wb_en    = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;
        case (state_q)
            IDLE: state_d = start ? LOAD_START : IDLE;
            LOAD_START: begin
                sel_pc  = 2'b01;
                load_pc = 1'b1;
                busy    = 1'b1;
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                load_ir  = imem_ready;
                busy     = 1'b1;
                state_d  = imem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                busy    = 1'b1;
                state_d = halt_instr ? HALT : EXECUTE;
            end
            EXECUTE: begin
                exec_en = 1'b1;
                busy    = 1'b1;
                state_d = stall ? EXECUTE : WRITEBACK;
            end
            WRITEBACK: begin
                sel_pc  = branch_taken ? 2'b11 : 2'b00;
                load_pc = 1'b1;
                wb_en   = 1'b1;
                busy    = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                state_d = start ? LOAD_START : HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign retired_cnt = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table vectors, random stimulus against an instruction-level model, and reset/wrap sequences.
module tb_pc_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, imem_ready = 1'b0, halt_instr = 1'b0, stall = 1'b0, branch_taken = 1'b0;
    logic [1:0]  sel_pc, sel_pc2;
    logic        load_pc, imem_req, load_ir, exec_en, wb_en, busy, halted;
    logic        load_pc2, imem_req2, load_ir2, exec_en2, wb_en2, busy2, halted2;
    logic [15:0] retired_cnt;
    logic [1:0]  retired_cnt2;
    logic [8:0]  act9;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
        .halt_instr(halt_instr), .stall(stall), .branch_taken(branch_taken),
        .sel_pc(sel_pc), .load_pc(load_pc), .imem_req(imem_req), .load_ir(load_ir),
        .exec_en(exec_en), .wb_en(wb_en), .busy(busy), .halted(halted),
        .retired_cnt(retired_cnt)
    );

    pc_sequencer #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready),
        .halt_instr(halt_instr), .stall(stall), .branch_taken(branch_taken),
        .sel_pc(sel_pc2), .load_pc(load_pc2), .imem_req(imem_req2), .load_ir(load_ir2),
        .exec_en(exec_en2), .wb_en(wb_en2), .busy(busy2), .halted(halted2),
        .retired_cnt(retired_cnt2)
    );

    assign act9 = {sel_pc, load_pc, imem_req, load_ir, exec_en, wb_en, busy, halted};

    int passed = 0, total = 0;

    // Model: mode 0 idle, 1 loading start address, 2 running an instruction, 3 halted.
    // While running, stage counts the instruction's phase: 0 fetch, 1 decode, 2 execute, 3 writeback.
    int          mode = 0, stage = 0;
    int unsigned mcnt = 0;

    function automatic logic [8:0] model_out(input logic ir, input logic br);
        logic run, wb;
        logic [1:0] sel;
        run = (mode == 2);
        wb  = run && stage == 3;
        sel = (mode == 1) ? 2'b01 : (wb && br) ? 2'b11 : 2'b00;
        return {sel, (mode == 1) || wb, run && stage == 0, run && stage == 0 && ir,
                run && stage == 2, wb, mode == 1 || run, mode == 3};
    endfunction

    task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    endtask

    task automatic model_reset();
        mode = 0;
        stage = 0;
        mcnt = 0;
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic step(input logic st, ir, hi, sl, br, input logic use_exp, input logic [8:0] exp);
        start = st; imem_ready = ir; halt_instr = hi; stall = sl; branch_taken = br;
        #3;
        check9("model_outputs", act9, model_out(ir, br));
        checkn("retired_cnt", int'(retired_cnt), int'(mcnt % 65536));
        checkn("retired_cnt_w2", int'(retired_cnt2), int'(mcnt % 4));
        if (use_exp) check9("table_vector", act9, exp);
        case (mode)
            0: if (st) mode = 1;
            1: begin mode = 2; stage = 0; mcnt = 0; end
            2: case (stage)
                0: if (ir) stage = 1;
                1: if (hi) mode = 3; else stage = 2;
                2: if (!sl) stage = 3;
                default: begin mcnt++; stage = 0; end
            endcase
            default: if (st) mode = 1;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset_check(input string name);
        #2 rst_n = 1'b0;
        #1;
        check9(name, act9, 9'b0);
        checkn({name, "_cnt"}, int'(retired_cnt), 0);
        checkn({name, "_cnt_w2"}, int'(retired_cnt2), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic st, ir, hi, sl, br;
        logic [8:0] exp;
    } vec_t;
    vec_t tbl[20];

    initial begin
        // exp = {sel_pc, load_pc, imem_req, load_ir, exec_en, wb_en, busy, halted}
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_0000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b01_1000010};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0100010};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b00_0100010};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_0110010};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b00_0000010};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'b00_0001010};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00_0001010};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b00_0001010};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0001010};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_1000110};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_0110010};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0000010};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0001010};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b11_1000110};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b00_0110010};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b00_0000010};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0000001};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0000001};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b01_1000010};

        repeat (2) @(posedge clk);
        #1;
        check9("reset_outputs", act9, 9'b0);
        checkn("reset_cnt", int'(retired_cnt), 0);
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 20; i++)
            step(tbl[i].st, tbl[i].ir, tbl[i].hi, tbl[i].sl, tbl[i].br, 1'b1, tbl[i].exp);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 1'b0, 9'b0);

        async_reset_check("async_rst_random");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0);
        checkn("straight_5_cnt16", int'(retired_cnt), 5);
        checkn("straight_5_wrap_w2", int'(retired_cnt2), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'b00_0001010);
        async_reset_check("async_rst_mid_execute");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
